// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-cycle data memory (word addressed, four byte lanes with
// active-low write enables) between two requesters. Requester 0 is the CPU
// execute stage and requester 1 is the loader/debug port. Ownership is
// round-robin with a bounded burst length. Each beat captures the addressed
// word into a registered read-data output and pulses a one-cycle valid strobe.
//
// Ports:
//   clk, rstd                    clock, asynchronous active-low reset
//   r0_*/r1_* req,addr,wdata,    requester inputs; wren is active-low per byte,
//             wren                4'b1111 means read
//   r0_gnt, r1_gnt               registered grant (state is OWN0 / OWN1)
//   r0_rvalid, r1_rvalid         one-cycle strobe after each beat
//   r0_rdata, r1_rdata           captured read data, held until next strobe
//   mem_addr, mem_wdata,         memory request bus, idle values outside a beat
//   mem_wren
//   mem_rdata                    combinational memory read data
module dmem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rstd,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [3:0]        r0_wren,
   input  logic              r1_req,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [3:0]        r1_wren,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r0_rvalid,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wren,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t           state, state_nxt;
   logic             ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] cnt_sat;
   logic [CNT_W:0]   cnt_plus;
   logic             burst_done;
   logic             beat0, beat1;

   // A beat only happens while the owner is actually requesting; the cycle
   // after an owner drops req keeps the grant but performs no access.
   assign beat0  = (state == OWN0) && r0_req;
   assign beat1  = (state == OWN1) && r1_req;
   assign r0_gnt = (state == OWN0);
   assign r1_gnt = (state == OWN1);

   // The beat counter saturates at MAX_BURST so an uncontested owner can
   // stream forever without wrapping back into a short burst.
   assign cnt_plus   = {1'b0, cnt} + 1'b1;
   assign burst_done = (cnt_plus >= (CNT_W+1)'(MAX_BURST));
   assign cnt_sat    = (cnt == CNT_W'(MAX_BURST)) ? cnt : cnt_plus[CNT_W-1:0];

   // State, pointer and burst counter; reset drops to IDLE asynchronously so
   // the memory write enable deasserts the moment rstd falls.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state <= IDLE;
         ptr   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state decision. A forced handover at the burst limit has no empty
   // cycle; a release is decided in the granted cycle after req falls.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (r0_req && r1_req) begin
               state_nxt = ptr ? OWN1 : OWN0;
            end else if (r0_req) begin
               state_nxt = OWN0;
            end else if (r1_req) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (r0_req) begin
               if (!burst_done || !r1_req) begin
                  cnt_nxt = cnt_sat;
               end else begin
                  state_nxt = OWN1;
                  cnt_nxt   = '0;
                  ptr_nxt   = 1'b0;
               end
            end else if (r1_req) begin
               state_nxt = OWN1;
               cnt_nxt   = '0;
               ptr_nxt   = 1'b0;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               ptr_nxt   = 1'b1;
            end
         end
         OWN1: begin
            if (r1_req) begin
               if (!burst_done || !r0_req) begin
                  cnt_nxt = cnt_sat;
               end else begin
                  state_nxt = OWN0;
                  cnt_nxt   = '0;
                  ptr_nxt   = 1'b1;
               end
            end else if (r0_req) begin
               state_nxt = OWN0;
               cnt_nxt   = '0;
               ptr_nxt   = 1'b1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               ptr_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Memory bus mux; outside a beat the bus is parked with writes disabled.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wren  = 4'b1111;
      if (beat0) begin
         mem_addr  = r0_addr;
         mem_wdata = r0_wdata;
         mem_wren  = r0_wren;
      end else if (beat1) begin
         mem_addr  = r1_addr;
         mem_wdata = r1_wdata;
         mem_wren  = r1_wren;
      end
   end

   // Every beat, writes included, captures the pre-write word on the closing
   // edge and strobes valid for exactly the following cycle.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= beat0;
         r1_rvalid <= beat1;
         if (beat0) begin
            r0_rdata <= mem_rdata;
         end
         if (beat1) begin
            r1_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 256x32 byte-lane memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rstd;
   logic        r0_req, r1_req;
   logic [7:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic [3:0]  r0_wren, r1_wren;
   logic        r0_gnt, r1_gnt;
   logic        r0_rvalid, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wren;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:255];
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = '0;
   logic [31:0] load_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rstd      (rstd),
      .r0_req    (r0_req),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_wren   (r0_wren),
      .r1_req    (r1_req),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_wren   (r1_wren),
      .r0_gnt    (r0_gnt),
      .r1_gnt    (r1_gnt),
      .r0_rvalid (r0_rvalid),
      .r1_rvalid (r1_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_rdata  (r1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wren  (mem_wren),
      .mem_rdata (mem_rdata)
   );

   // Single-cycle memory: combinational read, byte-lane write on the edge.
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (!mem_wren[b]) begin
               mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int port, input logic req, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wren);
      if (port == 0) begin
         r0_req = req; r0_addr = addr; r0_wdata = wdata; r0_wren = wren;
      end else begin
         r1_req = req; r1_addr = addr; r1_wdata = wdata; r1_wren = wren;
      end
   endtask

   task automatic loadWord(input logic [7:0] a, input logic [31:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      tick();
      load_en   = 1'b0;
   endtask

   function automatic logic getGnt(input int p);
      return (p == 0) ? r0_gnt : r1_gnt;
   endfunction

   function automatic logic getRvalid(input int p);
      return (p == 0) ? r0_rvalid : r1_rvalid;
   endfunction

   function automatic logic [31:0] getRdata(input int p);
      return (p == 0) ? r0_rdata : r1_rdata;
   endfunction

   task automatic resetDut();
      applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
      applyStimulus(1, 1'b0, 8'h00, 32'h0, 4'hF);
      rstd = 1'b0;
      #1;
      checkOutput("rst_r0_gnt",    r0_gnt,    1'b0);
      checkOutput("rst_r1_gnt",    r1_gnt,    1'b0);
      checkOutput("rst_r0_rvalid", r0_rvalid, 1'b0);
      checkOutput("rst_r1_rvalid", r1_rvalid, 1'b0);
      checkOutput("rst_r0_rdata",  r0_rdata,  32'h0);
      checkOutput("rst_r1_rdata",  r1_rdata,  32'h0);
      checkOutput("rst_mem_wren",  mem_wren,  4'hF);
      checkOutput("rst_mem_addr",  mem_addr,  8'h00);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      repeat (2) tick();
      rstd = 1'b1;
   endtask

   // One isolated access from IDLE: grant, beat, decision cycle, back to IDLE.
   task automatic doAccess(input int port, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wren, input logic [31:0] exp_rdata);
      applyStimulus(port, 1'b1, addr, wdata, wren);
      tick();
      #1;
      checkOutput("acc_gnt",      getGnt(port), 1'b1);
      checkOutput("acc_mem_addr", mem_addr,     addr);
      checkOutput("acc_mem_wren", mem_wren,     wren);
      checkOutput("acc_mem_wdata", mem_wdata,   wdata);
      tick();
      applyStimulus(port, 1'b0, 8'h00, 32'h0, 4'hF);
      #1;
      checkOutput("acc_dec_gnt",    getGnt(port),    1'b1);
      checkOutput("acc_dec_addr",   mem_addr,        8'h00);
      checkOutput("acc_rvalid",     getRvalid(port), 1'b1);
      checkOutput("acc_rdata",      getRdata(port),  exp_rdata);
      tick();
      checkOutput("acc_idle_gnt",   getGnt(port),    1'b0);
      checkOutput("acc_idle_rvalid", getRvalid(port), 1'b0);
      checkOutput("acc_rdata_hold", getRdata(port),  exp_rdata);
   endtask

   logic e0, e1, b0, b1, prev0, prev1;
   int   rv0, rv1;

   initial begin
      rstd = 1'b0;
      applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
      applyStimulus(1, 1'b0, 8'h00, 32'h0, 4'hF);
      loadWord(8'h03, 32'h12345678);
      loadWord(8'h05, 32'hFFFFFFFF);
      loadWord(8'h10, 32'hCAFEBABE);
      loadWord(8'h20, 32'hA0A00020);
      loadWord(8'h30, 32'hB0B00030);

      // Reset asserted in the middle of a full-word write beat.
      resetDut();
      applyStimulus(0, 1'b1, 8'h03, 32'hDEADBEEF, 4'b0000);
      tick();
      #1;
      checkOutput("midw_gnt",  r0_gnt,   1'b1);
      checkOutput("midw_wren", mem_wren, 4'b0000);
      #2;
      rstd = 1'b0;
      #1;
      checkOutput("midrst_wren",  mem_wren,  4'hF);
      checkOutput("midrst_gnt",   r0_gnt,    1'b0);
      checkOutput("midrst_addr",  mem_addr,  8'h00);
      checkOutput("midrst_wdata", mem_wdata, 32'h0);
      applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
      tick();
      rstd = 1'b1;
      doAccess(0, 8'h03, 32'h0, 4'hF, 32'h12345678);

      // Single read and byte-lane write then read back.
      doAccess(0, 8'h10, 32'h0, 4'hF, 32'hCAFEBABE);
      doAccess(1, 8'h05, 32'h11223344, 4'b1110, 32'hFFFFFFFF);
      doAccess(1, 8'h05, 32'h0, 4'hF, 32'hFFFFFF44);

      // Both stream from reset: blocks of four beats, r0 first.
      resetDut();
      applyStimulus(0, 1'b1, 8'h20, 32'h0, 4'hF);
      applyStimulus(1, 1'b1, 8'h30, 32'h0, 4'hF);
      prev0 = 1'b0; prev1 = 1'b0; rv0 = 0; rv1 = 0;
      for (int c = 1; c <= 22; c++) begin
         tick();
         if (c == 21) begin
            applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
            applyStimulus(1, 1'b0, 8'h00, 32'h0, 4'hF);
         end
         #1;
         e0 = (c <= 21) && (((c - 1) / 4) % 2 == 0);
         e1 = (c <= 21) && !e0;
         b0 = e0 && (c <= 20);
         b1 = e1 && (c <= 20);
         checkOutput("str_r0_gnt",    r0_gnt,    e0);
         checkOutput("str_r1_gnt",    r1_gnt,    e1);
         checkOutput("str_r0_rvalid", r0_rvalid, prev0);
         checkOutput("str_r1_rvalid", r1_rvalid, prev1);
         checkOutput("str_mem_addr",  mem_addr,  b0 ? 8'h20 : (b1 ? 8'h30 : 8'h00));
         if (prev0) checkOutput("str_r0_rdata", r0_rdata, 32'hA0A00020);
         if (prev1) checkOutput("str_r1_rdata", r1_rdata, 32'hB0B00030);
         if (r0_rvalid) rv0++;
         if (r1_rvalid) rv1++;
         prev0 = b0;
         prev1 = b1;
      end
      checkOutput("str_r0_count", rv0, 12);
      checkOutput("str_r1_count", rv1, 8);

      // Release to IDLE moves the pointer to r1.
      resetDut();
      applyStimulus(0, 1'b1, 8'h20, 32'h0, 4'hF);
      tick();
      checkOutput("rel_c1_gnt", r0_gnt, 1'b1);
      tick();
      checkOutput("rel_c2_gnt",    r0_gnt,    1'b1);
      checkOutput("rel_c2_rvalid", r0_rvalid, 1'b1);
      tick();
      applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
      #1;
      checkOutput("rel_c3_gnt",  r0_gnt,   1'b1);
      checkOutput("rel_c3_wren", mem_wren, 4'hF);
      checkOutput("rel_c3_addr", mem_addr, 8'h00);
      tick();
      checkOutput("rel_c4_r0_gnt",  r0_gnt,    1'b0);
      checkOutput("rel_c4_r1_gnt",  r1_gnt,    1'b0);
      checkOutput("rel_c4_rvalid",  r0_rvalid, 1'b0);
      applyStimulus(0, 1'b1, 8'h20, 32'h0, 4'hF);
      applyStimulus(1, 1'b1, 8'h30, 32'h0, 4'hF);
      tick();
      checkOutput("ptr_r1_gnt", r1_gnt, 1'b1);
      checkOutput("ptr_r0_gnt", r0_gnt, 1'b0);
      tick();
      applyStimulus(1, 1'b0, 8'h00, 32'h0, 4'hF);
      #1;
      checkOutput("hand_r1_gnt",  r1_gnt,   1'b1);
      checkOutput("hand_addr",    mem_addr, 8'h00);
      tick();
      applyStimulus(0, 1'b0, 8'h00, 32'h0, 4'hF);
      #1;
      checkOutput("hand_r0_gnt",  r0_gnt,   1'b1);
      checkOutput("hand_r1_off",  r1_gnt,   1'b0);
      tick();
      checkOutput("end_r0_gnt",    r0_gnt,    1'b0);
      checkOutput("end_r0_rvalid", r0_rvalid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Grants must never overlap.
   always @(negedge clk) begin
      if (rstd) begin
         checkOutput("gnt_onehot", {31'b0, r0_gnt & r1_gnt}, 32'h0);
      end
   end

endmodule
